stopwatch_lap: RTL

//  Parametrised successor to the single-mode stopwatch. Counts MM:SS.cc with proper 60-second rollover.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/bcd2seven.sv | 26 ++
 rtl/digit_split.sv | 13 +
 rtl/sw_time_counter.sv | 73 +++++++
 rtl/stopwatch_lap.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: time fields, lap record,
// key indices and seven-segment display constants.
package stopwatch_pkg;

  localparam int unsigned FIELD_W    = 7;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned DIGITS     = 6;
  localparam int unsigned CC_MAX     = 99;
  localparam int unsigned SS_MAX     = 59;
  localparam int unsigned SEP_BIT_LO = 23;
  localparam int unsigned SEP_BIT_HI = 39;
  localparam int unsigned KEY_DOWN   = 0;
  localparam int unsigned KEY_UP     = 1;
  localparam int unsigned KEY_ESC    = 2;
  localparam int unsigned KEY_ENTER  = 3;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  typedef struct packed {
    logic [FIELD_W-1:0] mm;
    logic [FIELD_W-1:0] ss;
    logic [FIELD_W-1:0] cc;
  } lap_t;

  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_e;

endpackage

// File: rtl/bcd2seven.sv
// Active-high seven-segment encoder {dp,g,f,e,d,c,b,a}; non-BCD codes blank.
module bcd2seven
  import stopwatch_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_split.sv
// Splits a 0..99 binary field into its tens and ones BCD digits.
module digit_split
  import stopwatch_pkg::*;
(
  input  logic [FIELD_W-1:0] value,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);

  assign tens = 4'(value / FIELD_W'(10));
  assign ones = 4'(value % FIELD_W'(10));

endmodule

// File: rtl/sw_time_counter.sv
// Centisecond tick divider and cc/ss/mm carry chain for the stopwatch.
module sw_time_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10000,
  parameter int unsigned MIN_MAX  = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               run,
  output logic [FIELD_W-1:0] mm,
  output logic [FIELD_W-1:0] ss,
  output logic [FIELD_W-1:0] cc
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);

  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [FIELD_W-1:0] cc_q, cc_d;
  logic [FIELD_W-1:0] ss_q, ss_d;
  logic [FIELD_W-1:0] mm_q, mm_d;

  // Carry ripples only on the wrapping tick; clear overrides counting.
  always_comb begin
    tick_d = tick_q;
    cc_d   = cc_q;
    ss_d   = ss_q;
    mm_d   = mm_q;
    if (clr) begin
      tick_d = '0;
      cc_d   = '0;
      ss_d   = '0;
      mm_d   = '0;
    end else if (run) begin
      if (tick_q == TICK_W'(TICK_DIV - 1)) begin
        tick_d = '0;
        if (cc_q == FIELD_W'(CC_MAX)) begin
          cc_d = '0;
          if (ss_q == FIELD_W'(SS_MAX)) begin
            ss_d = '0;
            mm_d = (mm_q == FIELD_W'(MIN_MAX - 1)) ? '0 : mm_q + FIELD_W'(1);
          end else begin
            ss_d = ss_q + FIELD_W'(1);
          end
        end else begin
          cc_d = cc_q + FIELD_W'(1);
        end
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      cc_q   <= '0;
      ss_q   <= '0;
      mm_q   <= '0;
    end else begin
      tick_q <= tick_d;
      cc_q   <= cc_d;
      ss_q   <= ss_d;
      mm_q   <= mm_d;
    end
  end

  assign mm = mm_q;
  assign ss = ss_q;
  assign cc = cc_q;

endmodule

// File: rtl/stopwatch_lap.sv
// MM:SS.cc stopwatch with a lap ring buffer browsable by up/down keys,
// driving the shared six-digit seven-segment bus.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 10000,
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned MIN_MAX   = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     up,
  input  logic                     down,
  input  logic                     left,
  input  logic                     right,
  input  logic                     enter,
  input  logic                     esc,
  output logic [DIGITS*SEG_W-1:0]  out,
  output logic [DIGITS-1:0]        blk,
  output logic                     norm
);

  localparam int unsigned PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LAP_DEPTH + 1);
  localparam int unsigned IDX_W = CNT_W + 1;

  run_state_e         state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   lap_cnt_q, lap_cnt_d;
  logic [CNT_W-1:0]   view_q, view_d;
  logic [3:0]         mark_q, mark_d;
  lap_t               lap_mem_q [LAP_DEPTH];

  logic               rst_all_c;
  logic [3:0]         keys_c;
  logic [3:0]         press_c;
  logic               lap_we_c;
  logic               clr_c;
  logic               unused_keys_c;
  logic [FIELD_W-1:0] live_mm, live_ss, live_cc;
  lap_t               live_c;
  lap_t               disp_c;
  logic [IDX_W-1:0]   rd_sum_c;
  logic [PTR_W-1:0]   rd_idx_c;
  logic [3:0]         bcd_c [DIGITS];
  logic [SEG_W-1:0]   seg_c [DIGITS];

  assign rst_all_c     = rst | ~mode;
  assign keys_c        = {enter, esc, up, down};
  assign press_c       = keys_c & ~mark_q;
  assign unused_keys_c = left ^ right;

  sw_time_counter #(
    .TICK_DIV (TICK_DIV),
    .MIN_MAX  (MIN_MAX)
  ) u_time (
    .clk (clk),
    .rst (rst_all_c),
    .clr (clr_c),
    .run (state_q == ST_RUNNING),
    .mm  (live_mm),
    .ss  (live_ss),
    .cc  (live_cc)
  );

  assign live_c = {live_mm, live_ss, live_cc};

  // Only the highest-priority new press acts; every key still updates its marker.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    lap_cnt_d = lap_cnt_q;
    view_d    = view_q;
    mark_d    = keys_c;
    lap_we_c  = 1'b0;
    clr_c     = 1'b0;
    if (press_c[KEY_ENTER]) begin
      state_d = (state_q == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
    end else if (press_c[KEY_ESC]) begin
      view_d = '0;
      if (state_q == ST_RUNNING) begin
        lap_we_c = ~rst_all_c;
        wr_ptr_d = (wr_ptr_q == PTR_W'(LAP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (lap_cnt_q != CNT_W'(LAP_DEPTH)) begin
          lap_cnt_d = lap_cnt_q + CNT_W'(1);
        end
      end else begin
        clr_c     = 1'b1;
        wr_ptr_d  = '0;
        lap_cnt_d = '0;
      end
    end else if (press_c[KEY_UP]) begin
      if (view_q < lap_cnt_q) begin
        view_d = view_q + CNT_W'(1);
      end
    end else if (press_c[KEY_DOWN]) begin
      if (view_q != '0) begin
        view_d = view_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_all_c) begin
      state_q   <= ST_PAUSED;
      wr_ptr_q  <= '0;
      lap_cnt_q <= '0;
      view_q    <= '0;
      mark_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      lap_cnt_q <= lap_cnt_d;
      view_q    <= view_d;
      mark_q    <= mark_d;
    end
  end

  // Lap storage needs no reset: lap_cnt gates what can be viewed.
  always_ff @(posedge clk) begin
    if (lap_we_c) begin
      lap_mem_q[wr_ptr_q] <= live_c;
    end
  end

  // k-th newest lap lives at (wr_ptr - k) mod LAP_DEPTH.
  assign rd_sum_c = IDX_W'(wr_ptr_q) + IDX_W'(LAP_DEPTH) - IDX_W'(view_q);
  assign rd_idx_c = (rd_sum_c >= IDX_W'(LAP_DEPTH)) ? PTR_W'(rd_sum_c - IDX_W'(LAP_DEPTH))
                                                     : PTR_W'(rd_sum_c);
  assign disp_c   = (view_q == '0) ? live_c : lap_mem_q[rd_idx_c];

  digit_split u_split_cc (.value(disp_c.cc), .tens(bcd_c[1]), .ones(bcd_c[0]));
  digit_split u_split_ss (.value(disp_c.ss), .tens(bcd_c[3]), .ones(bcd_c[2]));
  digit_split u_split_mm (.value(disp_c.mm), .tens(bcd_c[5]), .ones(bcd_c[4]));

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd2seven u_seg (.bcd(bcd_c[g]), .seg(seg_c[g]));
  end

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      out[i*SEG_W +: SEG_W] = seg_c[i];
    end
    out[SEP_BIT_LO] = 1'b1;
    out[SEP_BIT_HI] = 1'b1;
  end

  assign norm = (view_q == '0);
  assign blk  = norm ? '0 : '1;

endmodule
